// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, RUN} reset_seq_state_t;

  // Width of the phase counter: it must reach the longer of the stretch time
  // and the full release span, minus one.
  function automatic int seq_cnt_width(input int stretch_cycles,
                                       input int stagger,
                                       input int n_out);
    int span;
    span = (stretch_cycles > stagger * (n_out - 1)) ? stretch_cycles
                                                    : stagger * (n_out - 1);
    return (span > 1) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/reset_sync_cell.sv
// Async-assert / sync-deassert reset synchroniser; the chain shifts in ones
// after reset_n rises and is cleared at once when it falls.
module reset_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic sync_rst_n
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequences active-low resets: async assertion, synchronised release, a
// stretch period, then staggered per-domain release; also handles soft resets.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int N_OUT          = 4,
  parameter int STAGGER        = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sw_reset_req,
  output logic [N_OUT-1:0] rst_n_out,
  output logic             reset_active,
  output logic [CNT_W-1:0] sw_reset_count
);

  localparam int CW       = seq_cnt_width(STRETCH_CYCLES, STAGGER, N_OUT);
  localparam int LAST_REL = STAGGER * (N_OUT - 1) - 1;

  reset_seq_state_t state_q;
  logic [CW-1:0]    cnt_q;
  logic [N_OUT-1:0] rst_q;
  logic             active_q;
  logic [CNT_W-1:0] sw_cnt_q;
  logic [CNT_W-1:0] sw_cnt_d;
  logic             sync_rst_n;
  logic             sw_accept;

  reset_sync_cell #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .sync_rst_n(sync_rst_n)
  );

  // Soft resets only restart a sequence that has already begun releasing.
  assign sw_accept = sw_reset_req && ((state_q == RELEASE) || (state_q == RUN));
  assign sw_cnt_d  = (&sw_cnt_q) ? sw_cnt_q : sw_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      rst_q    <= '0;
      active_q <= 1'b1;
      sw_cnt_q <= '0;
    end else if (sw_accept) begin
      state_q  <= STRETCH;
      cnt_q    <= '0;
      rst_q    <= '0;
      active_q <= 1'b1;
      sw_cnt_q <= sw_cnt_d;
    end else begin
      case (state_q)
        HOLD: begin
          if (sync_rst_n) begin
            state_q <= STRETCH;
            cnt_q   <= '0;
          end
        end
        STRETCH: begin
          if (cnt_q == CW'(STRETCH_CYCLES - 1)) begin
            cnt_q    <= '0;
            rst_q[0] <= 1'b1;
            if (N_OUT == 1) begin
              state_q  <= RUN;
              active_q <= 1'b0;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          cnt_q <= cnt_q + CW'(1);
          for (int i = 1; i < N_OUT; i++) begin
            if (cnt_q == CW'(STAGGER * i - 1)) begin
              rst_q[i] <= 1'b1;
            end
          end
          if (cnt_q == CW'(LAST_REL)) begin
            state_q  <= RUN;
            active_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign rst_n_out      = rst_q;
  assign reset_active   = active_q;
  assign sw_reset_count = sw_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a CNT_W=2 instance share
// stimulus and are checked every cycle against an edge-count schedule model.
module tb_reset_sequencer;

  localparam int SYNC_STAGES    = 2;
  localparam int STRETCH_CYCLES = 16;
  localparam int N_OUT          = 4;
  localparam int STAGGER        = 4;
  localparam int CNT_W          = 8;
  localparam int CNT_W_S        = 2;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;
  localparam int CNT_MAX_S      = (1 << CNT_W_S) - 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sw_reset_req = 1'b0;
  logic [N_OUT-1:0]   rst_n_out, rst_n_out_s;
  logic               reset_active, reset_active_s;
  logic [CNT_W-1:0]   sw_reset_count;
  logic [CNT_W_S-1:0] sw_reset_count_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: edges since reset_n rose, and the edge that started the
  // current schedule (power-on start is edge SYNC_STAGES+1).
  int edge_n    = 0;
  int base_n    = SYNC_STAGES + 1;
  int exp_cnt   = 0;
  int exp_cnt_s = 0;
  bit chk_en    = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES(SYNC_STAGES), .STRETCH_CYCLES(STRETCH_CYCLES),
    .N_OUT(N_OUT), .STAGGER(STAGGER), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req),
    .rst_n_out(rst_n_out), .reset_active(reset_active),
    .sw_reset_count(sw_reset_count)
  );

  reset_sequencer #(
    .SYNC_STAGES(SYNC_STAGES), .STRETCH_CYCLES(STRETCH_CYCLES),
    .N_OUT(N_OUT), .STAGGER(STAGGER), .CNT_W(CNT_W_S)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req),
    .rst_n_out(rst_n_out_s), .reset_active(reset_active_s),
    .sw_reset_count(sw_reset_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_OUT-1:0] exp_rst(input int n, input int b);
    logic [N_OUT-1:0] v;
    for (int i = 0; i < N_OUT; i++) v[i] = (n >= b + STRETCH_CYCLES + STAGGER * i);
    return v;
  endfunction

  function automatic logic exp_active(input int n, input int b);
    return n < b + STRETCH_CYCLES + STAGGER * (N_OUT - 1);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_n    <= 0;
      base_n    <= SYNC_STAGES + 1;
      exp_cnt   <= 0;
      exp_cnt_s <= 0;
    end else begin
      edge_n <= edge_n + 1;
      if (sw_reset_req && (edge_n + 1 >= base_n + STRETCH_CYCLES + 1)) begin
        base_n    <= edge_n + 1;
        exp_cnt   <= (exp_cnt < CNT_MAX) ? exp_cnt + 1 : exp_cnt;
        exp_cnt_s <= (exp_cnt_s < CNT_MAX_S) ? exp_cnt_s + 1 : exp_cnt_s;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rst_n_out", rst_n_out, exp_rst(edge_n, base_n));
      check("rst_n_out_c2", rst_n_out_s, exp_rst(edge_n, base_n));
      check("reset_active", reset_active, exp_active(edge_n, base_n));
      check("reset_active_c2", reset_active_s, exp_active(edge_n, base_n));
      check("sw_count", sw_reset_count, exp_cnt);
      check("sw_count_c2", sw_reset_count_s, exp_cnt_s);
    end
  end

  // Drops reset_n 2 ns after a falling clock edge, checks the outputs fall
  // with no clock edge, then releases after low_ns.
  task automatic pulse_reset(input int low_ns);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_n_out", rst_n_out, '0);
    check("async_reset_active", reset_active, 1);
    check("async_sw_count", sw_reset_count, 0);
    #(low_ns - 1) reset_n = 1'b1;
  endtask

  task automatic wait_rise(input int i, input int exp_edge);
    int k;
    k = 0;
    while (!rst_n_out[i] && k < 200) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("rise_edge_bit%0d", i), edge_n, exp_edge);
  endtask

  task automatic wait_run(input int max_cycles);
    int k;
    k = 0;
    while (reset_active && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    check("run_timeout", reset_active, 0);
  endtask

  initial begin
    int t;
    int low;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rst_n_out", rst_n_out, '0);
    check("reset_active_init", reset_active, 1);
    check("reset_count_init", sw_reset_count, 0);

    // Power-on release at a non-edge time
    #2 reset_n = 1'b1;
    for (int i = 0; i < N_OUT; i++) wait_rise(i, SYNC_STAGES + 1 + STRETCH_CYCLES + STAGGER * i);
    wait_run(10);
    check("run_edge", edge_n, 31);

    // Single-cycle soft reset in RUN
    repeat (3) @(negedge clk);
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    t = edge_n;
    check("soft_rst_n_out", rst_n_out, '0);
    check("soft_count", sw_reset_count, 1);
    wait_rise(0, t + 16);
    wait_rise(3, t + 28);
    wait_run(10);

    // Request held through HOLD/STRETCH, then into RELEASE
    sw_reset_req = 1'b1;
    pulse_reset(25);
    t = 0;
    while (edge_n < 19 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("held_ignored_count", sw_reset_count, 0);
    repeat (40) @(negedge clk);
    check("held_restart_count", sw_reset_count, 3);
    sw_reset_req = 1'b0;
    wait_run(100);

    // Hard reset mid-RELEASE after bit1 is out
    pulse_reset(25);
    wait_rise(1, 23);
    repeat (2) @(negedge clk);
    pulse_reset(25);
    for (int i = 0; i < N_OUT; i++) wait_rise(i, SYNC_STAGES + 1 + STRETCH_CYCLES + STAGGER * i);
    wait_run(10);

    // Short glitch in RUN replays the whole sequence
    repeat (2) @(negedge clk);
    pulse_reset(2);
    wait_rise(0, 19);
    wait_rise(3, 31);
    wait_run(10);

    // Five soft resets, each reaching RUN, saturate the 2-bit counter
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      sw_reset_req = 1'b1;
      @(negedge clk);
      sw_reset_req = 1'b0;
      wait_run(100);
    end
    check("sat_count_c2", sw_reset_count_s, 3);
    check("count_c8", sw_reset_count, 5);

    // Random soft requests and reset glitches
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      sw_reset_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) begin
        low = $urandom_range(0, 3) * 10 + (($urandom_range(0, 1) != 0) ? 2 : 6);
        pulse_reset(low);
      end
    end
    sw_reset_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Produces the active-low asynchronous resets that the team's async-reset flops (d/clk/reset_n/q style) consume. A raw board reset is asserted to all outputs asynchronously. Deassertion is synchronised, stretched, and released to N downstream domains in a staggered order. It also accepts a synchronous software reset request, so one block sequences both power-on and soft resets.

Parameters:
SYNC_STAGES, 2, depth of the deassertion synchroniser chain (legal range >=2)
STRETCH_CYCLES, 16, clocks to hold all outputs low after the synchronised release (legal range >=1)
N_OUT, 4, number of sequenced reset outputs (legal range >=1)
STAGGER, 4, clocks between consecutive output releases (legal range >=1)
CNT_W, 8, width of the soft-reset event counter

Ports:
clk  input  1  single clock; all sequential logic is on the rising edge
reset_n  input  1  asynchronous, active-low raw reset; this polarity and synchronicity are fixed
sw_reset_req  input  1  synchronous soft-reset request, sampled on the rising edge of clk
rst_n_out  output  N_OUT  sequenced active-low resets; each bit drives downstream async reset_n pins
reset_active  output  1  high while any part of the sequence is in progress (state != RUN)
sw_reset_count  output  CNT_W  saturating count of accepted soft resets

Behaviour:
- All outputs come directly from flops, with no combinational gating after the flops.
- Reset (reset_n=0), effective immediately and asynchronously:
  - rst_n_out = all 0s
  - reset_active = 1
  - sw_reset_count = 0
  - sync chain = 0s; state = HOLD; internal counter = 0
- Synchroniser: a chain of SYNC_STAGES flops, asynchronously cleared and shifting in 1. Let E1 be the first rising edge with reset_n=1. The chain output is high after edge E_S, where S=SYNC_STAGES.
- FSM states: HOLD, STRETCH, RELEASE, RUN.
- HOLD: wait for the synchronised release. Go to STRETCH on the first edge at which the chain output is 1 (edge E_{S+1}), with cnt=0.
- STRETCH: cnt increments every edge. On the edge where cnt==STRETCH_CYCLES-1:
  - go to RELEASE
  - rst_n_out[0] <= 1
  - cnt <= 0
- RELEASE: cnt increments every edge. rst_n_out[i] <= 1 on the edge where cnt==STAGGER*i-1, for i>=1. The edge that releases bit N_OUT-1 also enters RUN. If N_OUT==1, STRETCH goes straight to RUN.
- Resulting timing at defaults: rst_n_out[i] rises after edge E_{S+1+STRETCH_CYCLES+STAGGER*i}, i.e. after edges E19, E23, E27 and E31.
- Bits, once released, stay high until the next reset or accepted soft reset.
- reset_active: registered; goes 0 on the same edge that enters RUN.
- Soft reset:
  - sw_reset_req=1 sampled in RELEASE or RUN at edge T causes, at edge T:
    - rst_n_out <= 0
    - state <= STRETCH, cnt <= 0
    - reset_active <= 1
    - sw_reset_count increments, saturating at 2^CNT_W-1
  - The release schedule then repeats from STRETCH: rst_n_out[0] rises after edge T+STRETCH_CYCLES.
  - Requests in HOLD or STRETCH are ignored and not counted.
  - A held-high request restarts the sequence every edge it is accepted (i.e. in RELEASE/RUN).
- reset_n low at any time, including mid-STRETCH, mid-RELEASE or mid soft reset: all outputs are forced low asynchronously and the full sequence restarts from HOLD. A reset_n glitch shorter than one clock period still causes the full sequence.
- The raw reset_n input is never gated combinationally into rst_n_out; only the async clear of the output flops sees it.

Decomposition:
- Package reset_seq_pkg:
  - typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, RUN} reset_seq_state_t
  - function clog2-based counter width: max of STRETCH_CYCLES and STAGGER*(N_OUT-1)
- Sub-module reset_sync_cell:
  - parameter SYNC_STAGES
  - ports clk, reset_n, sync_rst_n
  - async-assert / sync-deassert chain
  - instantiated once; reusable elsewhere

Test Plan:
1. Defaults; reset_n=0 for 3 clocks, then high at a non-edge time -> rst_n_out=4'b0000 and reset_active=1 throughout. Bit0 rises after edge E19, bit1 after E23, bit2 after E27, bit3 after E31. reset_active falls after E31.
2. In RUN, pulse sw_reset_req for 1 cycle at edge T -> rst_n_out=0000 after T. Bit0 high after T+16, bit3 after T+28. sw_reset_count=1.
3. sw_reset_req held high during HOLD and STRETCH -> no restart, sw_reset_count stays 0. Hold it into RELEASE -> sequence restarts every accepted edge, and the count increments per edge.
4. Drive reset_n low mid-RELEASE (after bit1 released) -> all bits 0 immediately, without waiting for a clock edge. sw_reset_count=0. The full 19/23/27/31 schedule repeats after release.
5. reset_n glitch low for 2 ns between edges while in RUN -> outputs drop asynchronously, then the full sequence replays.
6. With CNT_W=2, apply 5 soft resets, each allowed to reach RUN -> sw_reset_count saturates at 3.
